count_ctrl: RTL and testbench
=============================

Name: count_ctrl

Overview:
Sequencing controller for a free-running event counter, with the counter register held inside the block. It accepts start/stop/clear/load commands over a valid/ready handshake and paces increments with a programmable prescaler. It reports terminal-count events in one-shot or auto-reload mode. It sits between a host/config agent and any logic that consumes the count, tick and done outputs.

Parameters:
WIDTH, 8, counter width in bits.
PRESCALE_W, 4, prescaler compare width; one increment every cfg_prescale+1 cycles.

Ports:
clk  input  1  single clock; all logic on posedge.
reset  input  1  synchronous, active-high reset.
cmd_valid  input  1  command present.
cmd_ready  output  1  block can accept a command this cycle.
cmd_op  input  2  command code: 0 START, 1 STOP, 2 CLEAR, 3 LOAD.
cmd_data  input  WIDTH  load value; used only by LOAD.
cfg_limit  input  WIDTH  terminal count.
cfg_prescale  input  PRESCALE_W  prescale divisor minus one.
cfg_reload  input  1  1 = auto-reload, 0 = one-shot.
count  output  WIDTH  current counter value, registered.
state  output  2  0 IDLE, 1 RUN, 2 DONE; 3 is never driven.
tick  output  1  one-cycle pulse, registered, coincident with each count update from a tick event.
done  output  1  one-cycle pulse, registered, when count becomes cfg_limit.

Behaviour:
- Reset (reset=1 at posedge): count=0, state=IDLE, prescaler=0, tick=0, done=0, cmd_ready=0. cmd_ready rises at the first posedge with reset=0.
- A command is accepted when cmd_valid & cmd_ready at a posedge.
- cmd_ready is registered. It goes low for exactly one cycle after each accepted command, so at most one command is accepted per 2 cycles. A held cmd_valid is accepted when ready returns.
- Prescaler runs only in RUN. It increments each cycle.
- Tick event: in RUN with prescaler >= cfg_prescale. The >= compare covers cfg_prescale being lowered mid-count. On a tick event the prescaler clears to 0.
- On each tick event:
  - nxt = (count == cfg_limit) ? 0 : count+1, with modulo 2^WIDTH wrap.
  - count <= nxt; tick <= 1; done <= (nxt == cfg_limit).
  - If done is set and cfg_reload=0, state <= DONE.
- A count loaded above cfg_limit runs up to all-ones, wraps to 0, then continues to cfg_limit.
- cfg_limit=0 with reload: count stays 0 and done pulses on every tick.
- Commands, applied at the accepting edge:
  - START: IDLE/DONE -> RUN, prescaler=0. In RUN it is a no-op and does not disturb the prescaler.
  - STOP: RUN/DONE -> IDLE. Prescaler=0, count held.
  - CLEAR: count=0, prescaler=0. DONE -> IDLE; RUN stays RUN; IDLE stays IDLE.
  - LOAD: count=cmd_data, prescaler=0. DONE -> IDLE; RUN stays RUN.
- Collision: an accepted STOP, CLEAR or LOAD in the same cycle as a tick event wins.
  - The tick is suppressed that cycle: tick=0, done=0, count takes the command value.
  - START in RUN does not suppress a coincident tick.
- DONE state: count holds cfg_limit; no ticks. START from DONE resumes, and the first tick yields count=0.
- cfg_* inputs are sampled live every cycle. No shadow registers.
- Reset asserted mid-operation overrides everything at that edge and returns all outputs to their reset values.

Test Plan:
1. Reset, then limit=3, prescale=0, reload=0, START -> count 1,2,3 on consecutive cycles; tick high 3 cycles; done high only with count=3; state=DONE next; count holds 3.
2. limit=2, prescale=2, reload=1, START -> tick every 3rd cycle; count 1,2,0,1,2,0; done pulses with each count=2; state stays RUN.
3. LOAD 0xFE, limit=5, prescale=0, reload=0, then START -> count FF,00,01,...,05; done with 05; DONE.
4. Hold cmd_valid with STOP over 2 cycles in RUN, timed so acceptance lands on a tick edge -> accepted once, on the second cycle; count unchanged at that edge; tick=0; state=IDLE; cmd_ready low for 1 cycle after acceptance.
5. Reset for 1 cycle mid-RUN (count=0x40) -> count=0, state=IDLE, tick/done=0, cmd_ready=0 that cycle and 1 the next.
6. limit=0, prescale=1, reload=1, START -> count stays 0; tick and done pulse together every 2nd cycle.

Source files
------------

// File: rtl/count_ctrl.sv
// Event counter sequencer: start/stop/clear/load commands over valid/ready,
// prescaled increments, terminal-count done in one-shot or auto-reload mode.
//
//   state  | meaning
//   IDLE   | counter held, prescaler parked at 0, waiting for START
//   RUN    | prescaler advancing, count steps on each tick event
//   DONE   | one-shot terminal count reached, count holds cfg_limit
module count_ctrl #(
  parameter int WIDTH      = 8,
  parameter int PRESCALE_W = 4
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  cmd_valid,
  output logic                  cmd_ready,
  input  logic [1:0]            cmd_op,
  input  logic [WIDTH-1:0]      cmd_data,
  input  logic [WIDTH-1:0]      cfg_limit,
  input  logic [PRESCALE_W-1:0] cfg_prescale,
  input  logic                  cfg_reload,
  output logic [WIDTH-1:0]      count,
  output logic [1:0]            state,
  output logic                  tick,
  output logic                  done
);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_RUN  = 2'd1,
    S_DONE = 2'd2
  } state_t;

  localparam logic [1:0] OP_START = 2'd0;
  localparam logic [1:0] OP_STOP  = 2'd1;
  localparam logic [1:0] OP_CLEAR = 2'd2;
  localparam logic [1:0] OP_LOAD  = 2'd3;

  state_t                  state_q, state_d;
  logic [WIDTH-1:0]        count_q, count_d;
  logic [PRESCALE_W-1:0]   presc_q, presc_d;
  logic                    tick_q, tick_d;
  logic                    done_q, done_d;
  logic                    ready_q;
  logic                    accept;
  logic                    tick_ev;
  logic [WIDTH-1:0]        nxt;

  assign accept  = cmd_valid & ready_q;
  // >= rather than == so a lowered cfg_prescale cannot strand the prescaler
  assign tick_ev = (state_q == S_RUN) && (presc_q >= cfg_prescale);
  assign nxt     = (count_q == cfg_limit) ? '0 : count_q + 1'b1;

  always_comb begin
    state_d = state_q;
    count_d = count_q;
    presc_d = (state_q == S_RUN) ? presc_q + 1'b1 : presc_q;
    tick_d  = 1'b0;
    done_d  = 1'b0;

    if (tick_ev) begin
      count_d = nxt;
      presc_d = '0;
      tick_d  = 1'b1;
      done_d  = (nxt == cfg_limit);
      if ((nxt == cfg_limit) && !cfg_reload)
        state_d = S_DONE;
    end

    // STOP/CLEAR/LOAD override a coincident tick; START in RUN leaves it alone
    if (accept) begin
      case (cmd_op)
        OP_START: begin
          if (state_q != S_RUN) begin
            state_d = S_RUN;
            presc_d = '0;
          end
        end
        OP_STOP: begin
          state_d = S_IDLE;
          count_d = count_q;
          presc_d = '0;
          tick_d  = 1'b0;
          done_d  = 1'b0;
        end
        OP_CLEAR: begin
          state_d = (state_q == S_DONE) ? S_IDLE : state_q;
          count_d = '0;
          presc_d = '0;
          tick_d  = 1'b0;
          done_d  = 1'b0;
        end
        default: begin
          state_d = (state_q == S_DONE) ? S_IDLE : state_q;
          count_d = cmd_data;
          presc_d = '0;
          tick_d  = 1'b0;
          done_d  = 1'b0;
        end
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= S_IDLE;
      count_q <= '0;
      presc_q <= '0;
      tick_q  <= 1'b0;
      done_q  <= 1'b0;
      ready_q <= 1'b0;
    end else begin
      state_q <= state_d;
      count_q <= count_d;
      presc_q <= presc_d;
      tick_q  <= tick_d;
      done_q  <= done_d;
      ready_q <= ~accept;
    end
  end

  assign cmd_ready = ready_q;
  assign count     = count_q;
  assign state     = state_q;
  assign tick      = tick_q;
  assign done      = done_q;

endmodule

// File: tb/tb_count_ctrl.sv
// Directed bench for count_ctrl: hand-computed vectors checked one cycle at a
// time, outputs sampled 1 time unit after each rising edge.
module tb_count_ctrl;

  localparam int WIDTH      = 8;
  localparam int PRESCALE_W = 4;

  logic                  clk = 1'b0;
  logic                  reset;
  logic                  cmd_valid;
  logic                  cmd_ready;
  logic [1:0]            cmd_op;
  logic [WIDTH-1:0]      cmd_data;
  logic [WIDTH-1:0]      cfg_limit;
  logic [PRESCALE_W-1:0] cfg_prescale;
  logic                  cfg_reload;
  logic [WIDTH-1:0]      count;
  logic [1:0]            state;
  logic                  tick;
  logic                  done;

  int checks = 0;
  int errors = 0;

  localparam logic [1:0] START = 2'd0, STOP = 2'd1, CLEAR = 2'd2, LOAD = 2'd3;
  localparam logic [1:0] IDLE = 2'd0, RUN = 2'd1, DONE = 2'd2;

  count_ctrl #(.WIDTH(WIDTH), .PRESCALE_W(PRESCALE_W)) dut (
    .clk          (clk),
    .reset        (reset),
    .cmd_valid    (cmd_valid),
    .cmd_ready    (cmd_ready),
    .cmd_op       (cmd_op),
    .cmd_data     (cmd_data),
    .cfg_limit    (cfg_limit),
    .cfg_prescale (cfg_prescale),
    .cfg_reload   (cfg_reload),
    .count        (count),
    .state        (state),
    .tick         (tick),
    .done         (done)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%0h exp=%0h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // full observable snapshot
  task automatic chk_all(input string tag, input logic [7:0] c, input logic [1:0] s,
                         input logic t, input logic d);
    chk({tag, ".count"}, count, c);
    chk({tag, ".state"}, state, s);
    chk({tag, ".tick"}, tick, t);
    chk({tag, ".done"}, done, d);
  endtask

  // present a command for exactly one edge; caller ensures cmd_ready is high
  task automatic issue(input logic [1:0] op, input logic [7:0] data);
    chk("issue.ready", cmd_ready, 1'b1);
    cmd_valid = 1'b1;
    cmd_op    = op;
    cmd_data  = data;
    step();
    cmd_valid = 1'b0;
    chk("issue.ready_low", cmd_ready, 1'b0);
  endtask

  logic [7:0] exp2 [6];
  logic [7:0] exp3 [7];

  initial begin
    reset        = 1'b1;
    cmd_valid    = 1'b0;
    cmd_op       = START;
    cmd_data     = '0;
    cfg_limit    = 8'd3;
    cfg_prescale = 4'd0;
    cfg_reload   = 1'b0;

    // 1: reset values, then one-shot to limit 3
    step();
    step();
    chk_all("rst", 8'h00, IDLE, 1'b0, 1'b0);
    chk("rst.ready", cmd_ready, 1'b0);
    reset = 1'b0;
    step();
    chk("rst.ready_rise", cmd_ready, 1'b1);
    issue(START, 8'h00);
    chk_all("t1.start", 8'h00, RUN, 1'b0, 1'b0);
    step(); chk_all("t1.c1", 8'h01, RUN, 1'b1, 1'b0);
    step(); chk_all("t1.c2", 8'h02, RUN, 1'b1, 1'b0);
    step(); chk_all("t1.c3", 8'h03, DONE, 1'b1, 1'b1);
    step(); chk_all("t1.hold", 8'h03, DONE, 1'b0, 1'b0);
    step(); chk_all("t1.hold2", 8'h03, DONE, 1'b0, 1'b0);

    // 2: auto-reload, limit 2, tick every 3rd cycle
    cfg_limit    = 8'd2;
    cfg_prescale = 4'd2;
    cfg_reload   = 1'b1;
    issue(CLEAR, 8'h00);
    chk_all("t2.clear", 8'h00, IDLE, 1'b0, 1'b0);
    step();
    issue(START, 8'h00);
    exp2 = '{8'd1, 8'd2, 8'd0, 8'd1, 8'd2, 8'd0};
    for (int k = 0; k < 6; k++) begin
      step(); chk("t2.gap1", tick, 1'b0);
      step(); chk("t2.gap2", tick, 1'b0);
      step(); chk_all("t2.tick", exp2[k], RUN, 1'b1, exp2[k] == 8'd2);
    end

    // 3: loaded above limit wraps through 0xFF and 0x00
    issue(STOP, 8'h00);
    chk_all("t3.stop", 8'h00, IDLE, 1'b0, 1'b0);
    step();
    cfg_limit    = 8'd5;
    cfg_prescale = 4'd0;
    cfg_reload   = 1'b0;
    issue(LOAD, 8'hFE);
    chk_all("t3.load", 8'hFE, IDLE, 1'b0, 1'b0);
    step();
    issue(START, 8'h00);
    exp3 = '{8'hFF, 8'h00, 8'h01, 8'h02, 8'h03, 8'h04, 8'h05};
    for (int k = 0; k < 7; k++) begin
      step();
      chk_all("t3.seq", exp3[k], (k == 6) ? DONE : RUN, 1'b1, k == 6);
    end
    step(); chk_all("t3.hold", 8'h05, DONE, 1'b0, 1'b0);

    // 4: STOP held two cycles, accepted on the second, which is a tick edge
    cfg_limit    = 8'h80;
    cfg_prescale = 4'd1;
    cfg_reload   = 1'b1;
    issue(CLEAR, 8'h00);
    step();
    issue(START, 8'h00);
    cmd_valid = 1'b1;
    cmd_op    = STOP;
    step();
    chk_all("t4.wait", 8'h00, RUN, 1'b0, 1'b0);
    chk("t4.ready_back", cmd_ready, 1'b1);
    step();
    cmd_valid = 1'b0;
    chk_all("t4.accept", 8'h00, IDLE, 1'b0, 1'b0);
    chk("t4.ready_low", cmd_ready, 1'b0);
    step();
    chk_all("t4.after", 8'h00, IDLE, 1'b0, 1'b0);
    chk("t4.ready_high", cmd_ready, 1'b1);

    // 5: reset mid-RUN at count 0x40
    cfg_prescale = 4'd15;
    issue(LOAD, 8'h40);
    step();
    issue(START, 8'h00);
    step();
    chk_all("t5.pre", 8'h40, RUN, 1'b0, 1'b0);
    reset = 1'b1;
    step();
    chk_all("t5.rst", 8'h00, IDLE, 1'b0, 1'b0);
    chk("t5.rst_ready", cmd_ready, 1'b0);
    reset = 1'b0;
    step();
    chk_all("t5.post", 8'h00, IDLE, 1'b0, 1'b0);
    chk("t5.post_ready", cmd_ready, 1'b1);

    // 6: limit 0 with reload, done with every tick; START in RUN keeps the tick
    cfg_limit    = 8'd0;
    cfg_prescale = 4'd1;
    cfg_reload   = 1'b1;
    issue(START, 8'h00);
    for (int k = 0; k < 3; k++) begin
      step(); chk_all("t6.gap", 8'h00, RUN, 1'b0, 1'b0);
      step(); chk_all("t6.tick", 8'h00, RUN, 1'b1, 1'b1);
    end
    step(); chk_all("t6.gap_pre", 8'h00, RUN, 1'b0, 1'b0);
    issue(START, 8'h00);
    chk_all("t6.start_tick", 8'h00, RUN, 1'b1, 1'b1);
    step(); chk_all("t6.gap_post", 8'h00, RUN, 1'b0, 1'b0);
    step(); chk_all("t6.tick_post", 8'h00, RUN, 1'b1, 1'b1);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
